// File: rtl/sobel_filter.sv
// sobel_filter: streaming 3x3 neighbourhood filter for the grayscale camera path.
// Two line buffers (rows v-1 and v-2) feed a 3x3 window; the output pixel is
// tagged with the window-centre coordinates and lags the input by 4 cycles.
//
// Ports:
//   clk_in          pixel clock
//   rst_in          synchronous, active-high reset
//   mode_in         00 bypass, 01 Sobel magnitude, 10 Gaussian blur, 11 bypass;
//                   latched only at the frame-start pixel (0,0)
//   data_valid_in   single-cycle strobe qualifying pixel_in/hcount_in/vcount_in
//   pixel_in        8-bit grayscale pixel
//   hcount_in       column 0..HRES-1
//   vcount_in       row 0..VRES-1
//   data_valid_out  single-cycle output strobe
//   pixel_out       filtered pixel
//   hcount_out      window-centre column
//   vcount_out      window-centre row
//
// Optional build macro SOBEL_THRESHOLD_EN: Sobel mode emits 8'hFF when the
// saturated magnitude is >= THRESHOLD, else 8'h00.
module sobel_filter #(
  parameter int         HRES      = 320,
  parameter int         VRES      = 240,
  parameter logic [7:0] THRESHOLD = 8'd96
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [1:0]  mode_in,
  input  logic        data_valid_in,
  input  logic [7:0]  pixel_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic        data_valid_out,
  output logic [7:0]  pixel_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out
);

  localparam int AW = (HRES > 1) ? $clog2(HRES) : 1;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_SOBEL  = 2'b01,
    MODE_BLUR   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  // Line buffers: not reset, contents persist across reset.
  logic [7:0]    r_lb1 [HRES];
  logic [7:0]    r_lb2 [HRES];
  logic [AW-1:0] w_addr;
  logic [7:0]    w_lb1_rd;
  logic [7:0]    w_lb2_rd;

  assign w_addr   = hcount_in[AW-1:0];
  assign w_lb1_rd = r_lb1[w_addr];
  assign w_lb2_rd = r_lb2[w_addr];

  // Reads are combinational, so the old lb1 value moves to lb2 at the same edge.
  always_ff @(posedge clk_in) begin
    if (data_valid_in) begin
      r_lb2[w_addr] <= w_lb1_rd;
      r_lb1[w_addr] <= pixel_in;
    end
  end

  // Stage 1: window shift, mode latch, coordinate tagging.
  mode_t       r_mode;
  mode_t       w_mode_now;
  logic        w_frame_start;
  logic [7:0]  r_win [3][3];
  logic        r_s1_valid;
  logic        r_s1_border;
  mode_t       r_s1_mode;
  logic [10:0] r_s1_h;
  logic [9:0]  r_s1_v;

  assign w_frame_start = data_valid_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign w_mode_now    = w_frame_start ? mode_t'(mode_in) : r_mode;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_mode      <= MODE_BYPASS;
      r_win       <= '{default: '0};
      r_s1_valid  <= 1'b0;
      r_s1_border <= 1'b0;
      r_s1_mode   <= MODE_BYPASS;
      r_s1_h      <= '0;
      r_s1_v      <= '0;
    end else begin
      r_s1_valid <= data_valid_in && (hcount_in != 11'd0) && (vcount_in != 10'd0);
      if (data_valid_in) begin
        r_mode      <= w_mode_now;
        r_s1_mode   <= w_mode_now;
        r_s1_h      <= hcount_in - 11'd1;
        r_s1_v      <= vcount_in - 10'd1;
        r_s1_border <= (hcount_in == 11'd1) || (vcount_in == 10'd1);
        for (int unsigned r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= w_lb2_rd;
        r_win[1][2] <= w_lb1_rd;
        r_win[2][2] <= pixel_in;
      end
    end
  end

  // Stage 2: gradients and blur sum. Differences are 11-bit two's complement.
  logic [10:0] w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg, w_gx, w_gy;
  logic [11:0] w_blur_sum;

  always_comb begin
    w_gx_pos = {3'b0, r_win[0][2]} + {2'b0, r_win[1][2], 1'b0} + {3'b0, r_win[2][2]};
    w_gx_neg = {3'b0, r_win[0][0]} + {2'b0, r_win[1][0], 1'b0} + {3'b0, r_win[2][0]};
    w_gy_pos = {3'b0, r_win[2][0]} + {2'b0, r_win[2][1], 1'b0} + {3'b0, r_win[2][2]};
    w_gy_neg = {3'b0, r_win[0][0]} + {2'b0, r_win[0][1], 1'b0} + {3'b0, r_win[0][2]};
    w_gx     = w_gx_pos - w_gx_neg;
    w_gy     = w_gy_pos - w_gy_neg;
    w_blur_sum = {4'b0, r_win[0][0]} + {3'b0, r_win[0][1], 1'b0} + {4'b0, r_win[0][2]}
               + {3'b0, r_win[1][0], 1'b0} + {2'b0, r_win[1][1], 2'b0}
               + {3'b0, r_win[1][2], 1'b0}
               + {4'b0, r_win[2][0]} + {3'b0, r_win[2][1], 1'b0} + {4'b0, r_win[2][2]};
  end

  logic        r_s2_valid, r_s2_border;
  mode_t       r_s2_mode;
  logic [10:0] r_s2_h, r_s2_gx, r_s2_gy;
  logic [9:0]  r_s2_v;
  logic [7:0]  r_s2_blur, r_s2_ctr;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s2_valid <= 1'b0;
    end else begin
      r_s2_valid  <= r_s1_valid;
      r_s2_border <= r_s1_border;
      r_s2_mode   <= r_s1_mode;
      r_s2_h      <= r_s1_h;
      r_s2_v      <= r_s1_v;
      r_s2_gx     <= w_gx;
      r_s2_gy     <= w_gy;
      r_s2_blur   <= 8'(w_blur_sum >> 4);
      r_s2_ctr    <= r_win[1][1];
    end
  end

  // Stage 3: |Gx|+|Gy| saturated to 8 bits.
  logic [10:0] w_ax, w_ay;
  logic [11:0] w_mag;
  logic [7:0]  w_mag_sat;

  always_comb begin
    w_ax      = r_s2_gx[10] ? (~r_s2_gx + 11'd1) : r_s2_gx;
    w_ay      = r_s2_gy[10] ? (~r_s2_gy + 11'd1) : r_s2_gy;
    w_mag     = {1'b0, w_ax} + {1'b0, w_ay};
    w_mag_sat = (w_mag > 12'd255) ? 8'hFF : w_mag[7:0];
  end

  logic        r_s3_valid, r_s3_border;
  mode_t       r_s3_mode;
  logic [10:0] r_s3_h;
  logic [9:0]  r_s3_v;
  logic [7:0]  r_s3_mag, r_s3_blur, r_s3_ctr;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s3_valid <= 1'b0;
    end else begin
      r_s3_valid  <= r_s2_valid;
      r_s3_border <= r_s2_border;
      r_s3_mode   <= r_s2_mode;
      r_s3_h      <= r_s2_h;
      r_s3_v      <= r_s2_v;
      r_s3_mag    <= w_mag_sat;
      r_s3_blur   <= r_s2_blur;
      r_s3_ctr    <= r_s2_ctr;
    end
  end

  // Stage 4: mode select, border zeroing, output register.
  logic [7:0] w_pix;

  always_comb begin
    w_pix = r_s3_ctr;
    case (r_s3_mode)
`ifdef SOBEL_THRESHOLD_EN
      MODE_SOBEL: w_pix = (r_s3_mag >= THRESHOLD) ? 8'hFF : 8'h00;
`else
      MODE_SOBEL: w_pix = r_s3_mag;
`endif
      MODE_BLUR:  w_pix = r_s3_blur;
      default:    w_pix = r_s3_ctr;
    endcase
    if (r_s3_border) w_pix = '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      data_valid_out <= 1'b0;
      pixel_out      <= '0;
      hcount_out     <= '0;
      vcount_out     <= '0;
    end else begin
      data_valid_out <= r_s3_valid;
      if (r_s3_valid) begin
        pixel_out  <= w_pix;
        hcount_out <= r_s3_h;
        vcount_out <= r_s3_v;
      end
    end
  end

endmodule

// File: tb/tb_sobel_filter.sv
module tb_sobel_filter;
  localparam int         HRES = 20;
  localparam int         VRES = 10;
  localparam logic [7:0] THR  = 8'd96;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic [1:0]  mode_in = 2'b00;
  logic        data_valid_in = 1'b0;
  logic [7:0]  pixel_in = '0;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        data_valid_out;
  logic [7:0]  pixel_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;

  sobel_filter #(.HRES(HRES), .VRES(VRES), .THRESHOLD(THR)) dut (
    .clk_in(clk), .rst_in(rst_in), .mode_in(mode_in),
    .data_valid_in(data_valid_in), .pixel_in(pixel_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .data_valid_out(data_valid_out), .pixel_out(pixel_out),
    .hcount_out(hcount_out), .vcount_out(vcount_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; int h; int v; int px; } exp_t;
  exp_t q[$];

  int checks = 0;
  int passed = 0;
  int img[VRES][HRES];
  int frame_mode = 0;
  int cur_frame = -1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Filter result for a window p[r*3+c], r=row (0 top), c=column (0 left).
  function automatic int win_calc(input int m, input int p[9]);
    int gx, gy, mag, sum;
    if (m == 1) begin
      gx  = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
      gy  = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (mag > 255) mag = 255;
`ifdef SOBEL_THRESHOLD_EN
      return (mag >= int'(THR)) ? 255 : 0;
`else
      return mag;
`endif
    end else if (m == 2) begin
      sum = p[0] + 2*p[1] + p[2] + 2*p[3] + 4*p[4] + 2*p[5] + p[6] + 2*p[7] + p[8];
      return sum / 16;
    end
    return p[4];
  endfunction

  // Expected output for the input at (h,v), taken from the image seen so far.
  function automatic int exp_px(input int h, input int v, input int m);
    int p[9];
    if (h == 1 || v == 1) return 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r*3+c] = img[v-2+r][h-2+c];
    return win_calc(m, p);
  endfunction

  function automatic int pat_px(input int pat, input int h, input int v);
    case (pat)
      0: return 80;
      1: return (h < 10) ? 0 : 100;
      2: return (h*7 + v*13) & 255;
      default: return (3*h*h + 29*v + h*v) & 255;
    endcase
  endfunction

  task automatic drive(input int h, input int v, input int px);
    @(posedge clk); #1;
    data_valid_in = 1'b1;
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    pixel_in  = 8'(px);
    img[v][h] = px;
    if (h == 0 && v == 0) frame_mode = (mode_in == 2'b11) ? 0 : int'(mode_in);
    if (h >= 1 && v >= 1) q.push_back('{cyc + 4, h - 1, v - 1, exp_px(h, v, frame_mode)});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      data_valid_in = 1'b0;
    end
  endtask

  task automatic run_frame(input int id, input int pat, input logic [1:0] m, input int gap,
                           input int ch_h, input int ch_v, input logic [1:0] m2);
    cur_frame = id;
    mode_in = m;
    for (int v = 0; v < VRES; v++)
      for (int h = 0; h < HRES; h++) begin
        if (h == ch_h && v == ch_v) mode_in = m2;
        drive(h, v, pat_px(pat, h, v));
        if (gap > 0) idle(gap);
      end
    idle(8);
  endtask

  // Scoreboard compare plus literal spot checks on known centres.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due < cyc) begin
      check("missing_out", 0, 1);
      void'(q.pop_front());
    end
    if (data_valid_out) begin
      if (q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = q.pop_front();
        check("out_cycle", cyc, e.due);
        check("out_hcount", int'(hcount_out), e.h);
        check("out_vcount", int'(vcount_out), e.v);
        check("out_pixel", int'(pixel_out), e.px);
      end
      if (cur_frame == 0 && hcount_out == 5 && vcount_out == 5) check("uni_sobel", int'(pixel_out), 0);
      if (cur_frame == 1 && hcount_out == 5 && vcount_out == 5) check("uni_blur", int'(pixel_out), 80);
      if (cur_frame == 1 && hcount_out == 0 && vcount_out == 4) check("border_col0", int'(pixel_out), 0);
      if (cur_frame == 1 && hcount_out == 6 && vcount_out == 0) check("border_row0", int'(pixel_out), 0);
      if (cur_frame == 2 && vcount_out == 3) begin
        if (hcount_out == 9)  check("step_c9", int'(pixel_out), 255);
        if (hcount_out == 10) check("step_c10", int'(pixel_out), 255);
        if (hcount_out == 5)  check("step_c5", int'(pixel_out), 0);
        if (hcount_out == 11) check("step_c11", int'(pixel_out), 0);
      end
      if (cur_frame == 3 && hcount_out == 4 && vcount_out == 6) check("bypass_4_6", int'(pixel_out), 106);
      if (cur_frame == 5 && hcount_out == 12 && vcount_out == 7) check("late_bypass", int'(pixel_out), 207);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pv[9];
    int rst_cyc;
    exp_t keep[$];

    for (int i = 0; i < 9; i++) pv[i] = i + 1;
`ifdef SOBEL_THRESHOLD_EN
    check("model_sobel", win_calc(1, pv), 0);
`else
    check("model_sobel", win_calc(1, pv), 32);
`endif
    check("model_blur", win_calc(2, pv), 5);
    check("model_bypass", win_calc(0, pv), 5);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", int'(data_valid_out), 0);
    check("rst_pixel", int'(pixel_out), 0);
    check("rst_hcount", int'(hcount_out), 0);
    check("rst_vcount", int'(vcount_out), 0);
    @(posedge clk); #1;
    rst_in = 1'b0;
    idle(2);

    run_frame(0, 0, 2'b01, 0, -1, -1, 2'b01);  // uniform, Sobel
    run_frame(1, 0, 2'b10, 0, -1, -1, 2'b10);  // uniform, blur
    run_frame(2, 1, 2'b01, 0, -1, -1, 2'b01);  // vertical step, Sobel
    run_frame(3, 2, 2'b00, 2, -1, -1, 2'b00);  // bypass, sparse valids
    run_frame(4, 3, 2'b10, 0, -1, -1, 2'b10);  // blur, textured
    run_frame(5, 3, 2'b00, 0, 10, 5, 2'b01);   // mode change mid-frame
    run_frame(6, 3, 2'b01, 0, -1, -1, 2'b01);  // Sobel takes effect
    run_frame(7, 2, 2'b11, 0, -1, -1, 2'b11);  // reserved mode acts as bypass

    // Reset with three outputs in flight.
    cur_frame = 8;
    mode_in = 2'b00;
    for (int v = 0; v < 3; v++)
      for (int h = 0; h < ((v == 2) ? 5 : HRES); h++)
        drive(h, v, pat_px(3, h, v));
    @(posedge clk); #1;
    data_valid_in = 1'b0;
    rst_in = 1'b1;
    rst_cyc = cyc;
    keep.delete();
    foreach (q[i]) if (q[i].due <= rst_cyc) keep.push_back(q[i]);
    check("inflight_count", q.size() - keep.size(), 3);
    q = keep;
    frame_mode = 0;
    @(posedge clk); #1;
    rst_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_valid", int'(data_valid_out), 0);
      check("post_rst_pixel", int'(pixel_out), 0);
      check("post_rst_hcount", int'(hcount_out), 0);
      check("post_rst_vcount", int'(vcount_out), 0);
    end
    idle(2);

    run_frame(9, 2, 2'b01, 0, -1, -1, 2'b01);  // normal frame after reset

    idle(10);
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
